// File: rtl/decode_stage.sv
// RV32I/RV64I decode stage with optional M-extension decode.
// Registered output bundle, valid/ready handshake, and a register busy scoreboard.
module decode_stage #(
  parameter int XLEN = 32,
  parameter bit EN_M = 1'b0,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [2:0]      out_alu_op,
  output logic [1:0]      out_addr_alu_op,
  output logic [1:0]      out_wb_op,
  output logic [1:0]      out_jmp_op,
  output logic [1:0]      out_mem_op,
  output logic            out_fault,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic            flush
);

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_LD    = 7'b0000011;
  localparam logic [6:0] OPC_ST    = 7'b0100011;
  localparam logic [6:0] OPC_OPI   = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_FENCE = 7'b0001111;
  localparam logic [6:0] OPC_SYS   = 7'b1110011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      f3;
    logic [2:0]      alu;
    logic [1:0]      addr;
    logic [1:0]      wb;
    logic [1:0]      jmp;
    logic [1:0]      mem;
    logic            fault;
  } out_t;

  logic [6:0] opc;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  logic [6:0] f7;

  assign opc = in_inst[6:0];
  assign rd  = in_inst[11:7];
  assign f3  = in_inst[14:12];
  assign rs1 = in_inst[19:15];
  assign rs2 = in_inst[24:20];
  assign f7  = in_inst[31:25];

  logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                  in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u = {in_inst[31:12], 12'b0};
  assign imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                  in_inst[20], in_inst[30:21], 1'b0};

  out_t               dec;
  logic signed [31:0] imm32;
  logic               use1, use2;

  always_comb begin
    dec       = '0;
    imm32     = '0;
    use1      = 1'b0;
    use2      = 1'b0;
    dec.pc    = in_pc;
    dec.rd    = rd;
    dec.rs1   = rs1;
    dec.rs2   = rs2;
    dec.f3    = f3;
    unique case (opc)
      OPC_LUI: begin
        imm32  = imm_u;
        dec.wb = 2'd1;
      end
      OPC_AUIPC: begin
        imm32    = imm_u;
        dec.addr = 2'd1;
        dec.wb   = 2'd2;
      end
      OPC_JAL: begin
        imm32    = imm_j;
        dec.alu  = 3'd1;
        dec.addr = 2'd1;
        dec.wb   = 2'd1;
        dec.jmp  = 2'd1;
      end
      OPC_JALR: begin
        imm32     = imm_i;
        use1      = 1'b1;
        dec.alu   = 3'd1;
        dec.addr  = 2'd3;
        dec.wb    = 2'd1;
        dec.jmp   = 2'd1;
        dec.fault = (f3 != 3'd0);
      end
      OPC_BR: begin
        imm32    = imm_b;
        use1     = 1'b1;
        use2     = 1'b1;
        dec.addr = 2'd1;
        dec.jmp  = 2'd2;
      end
      OPC_LD: begin
        imm32    = imm_i;
        use1     = 1'b1;
        dec.addr = 2'd2;
        dec.wb   = 2'd1;
        dec.mem  = 2'd1;
      end
      OPC_ST: begin
        imm32    = imm_s;
        use1     = 1'b1;
        use2     = 1'b1;
        dec.addr = 2'd2;
        dec.alu  = 3'd4;
        dec.mem  = 2'd2;
      end
      OPC_OPI: begin
        imm32   = imm_i;
        use1    = 1'b1;
        dec.alu = 3'd5;
        dec.wb  = 2'd1;
      end
      OPC_OP: begin
        use1    = 1'b1;
        use2    = 1'b1;
        dec.alu = 3'd6;
        dec.wb  = 2'd1;
        unique case (1'b1)
          f7 == 7'b0000000: dec.fault = 1'b0;
          f7 == 7'b0100000:
            dec.fault = !((f3 == 3'd0) || (f3 == 3'd5));
          f7 == 7'b0000001: begin
            if (EN_M) dec.alu = 3'd7;
            else      dec.fault = 1'b1;
          end
          default: dec.fault = 1'b1;
        endcase
      end
      OPC_FENCE: dec.fault = 1'b0;
      OPC_SYS: begin
        dec.fault = !((rd == 5'd0) && (rs1 == 5'd0) &&
                      ((in_inst[31:20] == 12'd0) ||
                       (in_inst[31:20] == 12'd1)));
      end
      default: dec.fault = 1'b1;
    endcase
    dec.imm = XLEN'(imm32);
    // A faulting slot must not stall, write, jump or touch memory
    if (dec.fault) begin
      dec.alu  = 3'd0;
      dec.addr = 2'd0;
      dec.wb   = 2'd0;
      dec.jmp  = 2'd0;
      dec.mem  = 2'd0;
      use1     = 1'b0;
      use2     = 1'b0;
    end
  end

  logic [NREG-1:0] busy_q, busy_d, wb_mask, eff;
  logic            hazard, accept;
  out_t            out_q, out_d;
  logic            valid_q, valid_d;

  always_comb begin
    wb_mask = '0;
    if (wb_valid && (wb_rd != 5'd0) && (int'(wb_rd) < NREG))
      wb_mask[wb_rd] = 1'b1;
    eff = busy_q & ~wb_mask;
  end

  always_comb begin
    hazard = 1'b0;
    if (use1 && (int'(rs1) < NREG) && eff[rs1]) hazard = 1'b1;
    if (use2 && (int'(rs2) < NREG) && eff[rs2]) hazard = 1'b1;
    if ((dec.wb != 2'd0) && (int'(rd) < NREG) && eff[rd])
      hazard = 1'b1;
  end

  assign in_ready = (!valid_q || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    busy_d = eff;
    if (accept && !dec.fault && (dec.wb != 2'd0) &&
        (rd != 5'd0) && (int'(rd) < NREG))
      busy_d[rd] = 1'b1;
    if (flush) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      out_d   = dec;
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid       = valid_q;
  assign out_pc          = out_q.pc;
  assign out_imm         = out_q.imm;
  assign out_rd          = out_q.rd;
  assign out_rs1         = out_q.rs1;
  assign out_rs2         = out_q.rs2;
  assign out_funct3      = out_q.f3;
  assign out_alu_op      = out_q.alu;
  assign out_addr_alu_op = out_q.addr;
  assign out_wb_op       = out_q.wb;
  assign out_jmp_op      = out_q.jmp;
  assign out_mem_op      = out_q.mem;
  assign out_fault       = out_q.fault;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: scoreboard of expected decodes,
// hazard stalls, backpressure, flush, reset, and an RV64+M instance.
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [2:0]  alu;
    logic [1:0]  addr;
    logic [1:0]  wb;
    logic [1:0]  jmp;
    logic [1:0]  mem;
    logic        fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_inst = '0, in_pc = '0;
  logic        out_valid, out_ready = 1'b1;
  logic [31:0] out_pc, out_imm;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3, out_alu_op;
  logic [1:0]  out_addr_alu_op, out_wb_op, out_jmp_op, out_mem_op;
  logic        out_fault;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic        flush = 1'b0;

  logic        m_in_valid = 1'b0, m_in_ready;
  logic [31:0] m_in_inst = '0;
  logic [63:0] m_in_pc = '0;
  logic        m_out_valid, m_out_ready = 1'b1;
  logic [63:0] m_out_pc, m_out_imm;
  logic [4:0]  m_out_rd, m_out_rs1, m_out_rs2;
  logic [2:0]  m_out_funct3, m_out_alu_op;
  logic [1:0]  m_out_addr_alu_op, m_out_wb_op, m_out_jmp_op, m_out_mem_op;
  logic        m_out_fault;

  int   checks = 0;
  int   failures = 0;
  exp_t cur_exp = '0;
  exp_t sb[$];
  exp_t mon_e, mon_o;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_imm(out_imm),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_funct3(out_funct3), .out_alu_op(out_alu_op),
    .out_addr_alu_op(out_addr_alu_op), .out_wb_op(out_wb_op),
    .out_jmp_op(out_jmp_op), .out_mem_op(out_mem_op),
    .out_fault(out_fault),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush)
  );

  decode_stage #(.XLEN(64), .EN_M(1'b1), .NREG(32)) dut_m (
    .clk(clk), .rst_n(rst_n),
    .in_valid(m_in_valid), .in_ready(m_in_ready),
    .in_inst(m_in_inst), .in_pc(m_in_pc),
    .out_valid(m_out_valid), .out_ready(m_out_ready),
    .out_pc(m_out_pc), .out_imm(m_out_imm),
    .out_rd(m_out_rd), .out_rs1(m_out_rs1), .out_rs2(m_out_rs2),
    .out_funct3(m_out_funct3), .out_alu_op(m_out_alu_op),
    .out_addr_alu_op(m_out_addr_alu_op), .out_wb_op(m_out_wb_op),
    .out_jmp_op(m_out_jmp_op), .out_mem_op(m_out_mem_op),
    .out_fault(m_out_fault),
    .wb_valid(1'b0), .wb_rd(5'd0), .flush(1'b0)
  );

  function automatic exp_t mk(input logic [31:0] pc, imm,
                              input int rd, alu, addr, wb,
                              input int jmp, mem, fault);
    exp_t e;
    e.pc    = pc;
    e.imm   = imm;
    e.rd    = 5'(rd);
    e.alu   = 3'(alu);
    e.addr  = 2'(addr);
    e.wb    = 2'(wb);
    e.jmp   = 2'(jmp);
    e.mem   = 2'(mem);
    e.fault = 1'(fault);
    return e;
  endfunction

  // Scoreboard: push on accept, pop on output handshake
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        mon_o = {out_pc, out_imm, out_rd, out_alu_op, out_addr_alu_op,
                 out_wb_op, out_jmp_op, out_mem_op, out_fault};
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected got=%h required=none", mon_o);
        end else begin
          mon_e = sb.pop_front();
          if (mon_o !== mon_e) begin
            failures++;
            $display("FAIL sb_out got=%h required=%h", mon_o, mon_e);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(cur_exp);
    end
  end

  task automatic issue(input logic [31:0] inst, pc, input exp_t e,
                       output int cyc);
    logic acc;
    acc      = 1'b0;
    cyc      = 0;
    in_inst  = inst;
    in_pc    = pc;
    cur_exp  = e;
    in_valid = 1'b1;
    while (!acc && cyc < 20) begin
      @(negedge clk);
      acc = in_ready;
      cyc++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checks++;
    if (!acc) begin
      failures++;
      $display("FAIL issue_timeout inst=%h got=stalled required=accept",
               inst);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_imm, out_pc, out_fault, out_alu_op} !== '0) begin
      failures++;
      $display("FAIL reset_outs got=%b/%h/%h required=0",
               out_valid, out_imm, out_pc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || m_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b%b required=11", in_ready, m_in_ready);
    end
  endtask

  task automatic test_back_to_back;
    int c;
    logic [31:0] insts [9];
    exp_t        exps [9];
    insts[0] = 32'h12345537;
    exps[0]  = mk(32'h100, 32'h12345000, 10, 0, 0, 1, 0, 0, 0);
    insts[1] = 32'h80000017;
    exps[1]  = mk(32'h104, 32'h80000000, 0, 0, 1, 2, 0, 0, 0);
    insts[2] = 32'h00802003;
    exps[2]  = mk(32'h108, 32'h8, 0, 0, 2, 1, 0, 1, 0);
    insts[3] = 32'hFE20AE23;
    exps[3]  = mk(32'h10C, 32'hFFFFFFFC, 28, 4, 2, 0, 0, 2, 0);
    insts[4] = 32'hFE000FE3;
    exps[4]  = mk(32'h110, 32'hFFFFFFFE, 31, 0, 1, 0, 2, 0, 0);
    insts[5] = 32'h00000067;
    exps[5]  = mk(32'h114, 32'h0, 0, 1, 3, 1, 1, 0, 0);
    insts[6] = 32'h00000073;
    exps[6]  = mk(32'h118, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    insts[7] = 32'h0000000F;
    exps[7]  = mk(32'h11C, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    insts[8] = 32'h800000EF;
    exps[8]  = mk(32'h120, 32'hFFF00000, 1, 1, 1, 1, 1, 0, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      issue(insts[i], exps[i].pc, exps[i], c);
      checks++;
      if (c !== 1) begin
        failures++;
        $display("FAIL b2b_cycles idx=%0d got=%0d required=1", i, c);
      end
    end
    idle(2);
  endtask

  task automatic test_raw;
    int c;
    issue(32'h00100293, 32'h200, mk(32'h200, 1, 5, 5, 0, 1, 0, 0, 0), c);
    in_inst  = 32'h00528333;
    in_pc    = 32'h204;
    cur_exp  = mk(32'h204, 0, 6, 6, 0, 1, 0, 0, 0);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL raw_stall cyc=%0d got=%b required=0", i, in_ready);
      end
      @(posedge clk);
      #1;
    end
    wb_valid = 1'b1;
    wb_rd    = 5'd5;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL raw_release got=%b required=1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wb_rd    = 5'd6;
    @(posedge clk);
    #1;
    wb_valid = 1'b0;
    idle(1);
  endtask

  task automatic test_set_wins;
    int c;
    wb_valid = 1'b1;
    wb_rd    = 5'd9;
    issue(32'h00900493, 32'h240, mk(32'h240, 9, 9, 5, 0, 1, 0, 0, 0), c);
    wb_valid = 1'b0;
    in_inst  = 32'h00048013;
    in_pc    = 32'h244;
    cur_exp  = mk(32'h244, 0, 0, 5, 0, 1, 0, 0, 0);
    in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL set_wins_busy got=%b required=0", in_ready);
    end
    @(posedge clk);
    #1;
    wb_valid = 1'b1;
    wb_rd    = 5'd9;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL set_wins_clear got=%b required=1", in_ready);
    end
    @(posedge clk);
    #1;
    wb_valid = 1'b0;
    in_valid = 1'b0;
    idle(2);
  endtask

  task automatic test_backpressure;
    int c;
    out_ready = 1'b0;
    issue(32'h00100013, 32'h300, mk(32'h300, 1, 0, 5, 0, 1, 0, 0, 0), c);
    in_inst  = 32'h00200013;
    in_pc    = 32'h304;
    cur_exp  = mk(32'h304, 2, 0, 5, 0, 1, 0, 0, 0);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, out_pc, out_imm} !==
          {1'b0, 1'b1, 32'h300, 32'h1}) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d got=%b%b %h %h required=01 300 1",
                 i, in_ready, out_valid, out_pc, out_imm);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release got=%b required=1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain got=%b required=0", out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_illegal;
    int c;
    out_ready = 1'b1;
    issue(32'h02000033, 32'h400, mk(32'h400, 0, 0, 0, 0, 0, 0, 0, 1), c);
    issue(32'h022081B3, 32'h404, mk(32'h404, 0, 3, 0, 0, 0, 0, 0, 1), c);
    issue(32'h00018213, 32'h408, mk(32'h408, 0, 4, 5, 0, 1, 0, 0, 0), c);
    checks++;
    if (c !== 1) begin
      failures++;
      $display("FAIL fault_no_busy got=%0d cycles required=1", c);
    end
    issue(32'h000010E7, 32'h40C, mk(32'h40C, 0, 1, 0, 0, 0, 0, 0, 1), c);
    issue(32'h00200073, 32'h410, mk(32'h410, 0, 0, 0, 0, 0, 0, 0, 1), c);
    issue(32'h0000007F, 32'h414, mk(32'h414, 0, 0, 0, 0, 0, 0, 0, 1), c);
    issue(32'h40001033, 32'h418, mk(32'h418, 0, 0, 0, 0, 0, 0, 0, 1), c);
    issue(32'h40005033, 32'h41C, mk(32'h41C, 0, 0, 6, 0, 1, 0, 0, 0), c);
    idle(2);
  endtask

  task automatic test_flush;
    int c;
    out_ready = 1'b0;
    issue(32'h00700393, 32'h500, mk(32'h500, 7, 7, 5, 0, 1, 0, 0, 0), c);
    flush = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_ready got=%b required=0", in_ready);
    end
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_valid got=%b required=0", out_valid);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    issue(32'h00738433, 32'h504, mk(32'h504, 0, 8, 6, 0, 1, 0, 0, 0), c);
    checks++;
    if (c !== 1) begin
      failures++;
      $display("FAIL flush_busy7 got=%0d cycles required=1", c);
    end
    issue(32'h00008013, 32'h508, mk(32'h508, 0, 0, 5, 0, 1, 0, 0, 0), c);
    checks++;
    if (c !== 1) begin
      failures++;
      $display("FAIL flush_busy1 got=%0d cycles required=1", c);
    end
    idle(2);
  endtask

  task automatic test_m64;
    m_in_inst  = 32'h02000033;
    m_in_pc    = 64'h1000;
    m_in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (m_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL m_mul_ready got=%b required=1", m_in_ready);
    end
    @(posedge clk);
    #1;
    m_in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({m_out_valid, m_out_alu_op, m_out_fault, m_out_wb_op} !==
        {1'b1, 3'd7, 1'b0, 2'd1}) begin
      failures++;
      $display("FAIL m_mul_dec got=%b %0d %b %0d required=1 7 0 1",
               m_out_valid, m_out_alu_op, m_out_fault, m_out_wb_op);
    end
    @(posedge clk);
    #1;
    m_in_inst  = 32'h800000EF;
    m_in_pc    = 64'h2000;
    m_in_valid = 1'b1;
    @(posedge clk);
    #1;
    m_in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({m_out_imm, m_out_pc, m_out_jmp_op, m_out_rd} !==
        {64'hFFFFFFFFFFF00000, 64'h2000, 2'd1, 5'd1}) begin
      failures++;
      $display("FAIL m_jal_imm got=%h %h required=fffffffffff00000 2000",
               m_out_imm, m_out_pc);
    end
    @(posedge clk);
    #1;
    m_in_inst  = 32'h02000033;
    m_in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (m_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL m_x0_busy got=%b required=1", m_in_ready);
    end
    @(posedge clk);
    #1;
    m_in_valid = 1'b0;
  endtask

  task automatic test_reset_mid;
    int c;
    out_ready = 1'b0;
    issue(32'h00700393, 32'h600, mk(32'h600, 7, 7, 5, 0, 1, 0, 0, 0), c);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_pc, out_rd, out_wb_op} !== '0) begin
      failures++;
      $display("FAIL rst_async got=%b %h %0d required=0 0 0",
               out_valid, out_pc, out_rd);
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_ready got=%b required=1", in_ready);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    issue(32'h00738433, 32'h604, mk(32'h604, 0, 8, 6, 0, 1, 0, 0, 0), c);
    checks++;
    if (c !== 1) begin
      failures++;
      $display("FAIL rst_busy got=%0d cycles required=1", c);
    end
    idle(3);
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_raw;
    test_set_wins;
    test_backpressure;
    test_illegal;
    test_flush;
    test_m64;
    test_reset_mid;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
